// File: rtl/vx_tcu_uop_seq_pkg.sv
// Shared types and default geometry for the TCU micro-op sequencer.
// Struct field widths come from the default geometry; any override must fit in them.
// Register numbers are NUM_REGS_BITS wide.
package vx_tcu_uop_seq_pkg;

  // clog2 clamped to at least one bit so single-step dimensions still get a counter
  function automatic int up_clog2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  localparam int TCU_M_STEPS      = 2;
  localparam int TCU_N_STEPS      = 4;
  localparam int TCU_K_STEPS      = 4;
  localparam int TCU_A_SUB_BLOCKS = 1;
  localparam int TCU_B_SUB_BLOCKS = 2;
  localparam int TCU_RA           = 0;
  localparam int TCU_RB           = 10;
  localparam int TCU_RC           = 24;
  localparam int NUM_REGS_BITS    = 5;

  localparam int TCU_STEP_M_BITS  = up_clog2(TCU_M_STEPS);
  localparam int TCU_STEP_N_BITS  = up_clog2(TCU_N_STEPS);
  localparam int TCU_STEP_K_BITS  = up_clog2(TCU_K_STEPS);
  localparam int TCU_A_SUB_BITS   = up_clog2(TCU_A_SUB_BLOCKS);
  localparam int TCU_B_SUB_BITS   = up_clog2(TCU_B_SUB_BLOCKS);

  typedef struct packed {
    logic [TCU_STEP_M_BITS-1:0] step_m;
    logic [TCU_STEP_N_BITS-1:0] step_n;
    logic [TCU_STEP_K_BITS-1:0] step_k;
    logic [NUM_REGS_BITS-1:0]   rs1;
    logic [NUM_REGS_BITS-1:0]   rs2;
    logic [NUM_REGS_BITS-1:0]   rs3;
    logic [NUM_REGS_BITS-1:0]   rd;
    logic [TCU_A_SUB_BITS-1:0]  a_sub;
    logic [TCU_B_SUB_BITS-1:0]  b_sub;
    logic                       sop;
    logic                       eop;
  } tcu_uop_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } tcu_seq_state_e;

endpackage

// File: rtl/vx_tcu_uop_seq_step_ctr.sv
// Three-level wrapping step counter (m outer, n middle, k inner).
// Latency: count visible the cycle after i_inc; o_last is combinational from the count.
// Backpressure: holds its count whenever i_inc is low; i_clr has priority over i_inc.
module vx_tcu_uop_seq_step_ctr
  import vx_tcu_uop_seq_pkg::*;
#(
  parameter int M_STEPS = 2,
  parameter int N_STEPS = 4,
  parameter int K_STEPS = 4,
  parameter int MW      = up_clog2(M_STEPS),
  parameter int NW      = up_clog2(N_STEPS),
  parameter int KW      = up_clog2(K_STEPS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [MW-1:0] o_m,
  output logic [NW-1:0] o_n,
  output logic [KW-1:0] o_k,
  output logic          o_last
);

  logic [MW-1:0] r_m;
  logic [NW-1:0] r_n;
  logic [KW-1:0] r_k;
  logic          w_m_max;
  logic          w_n_max;
  logic          w_k_max;

  assign w_m_max = (r_m == MW'(M_STEPS - 1));
  assign w_n_max = (r_n == NW'(N_STEPS - 1));
  assign w_k_max = (r_k == KW'(K_STEPS - 1));
  assign o_last  = w_m_max && w_n_max && w_k_max;
  assign o_m     = r_m;
  assign o_n     = r_n;
  assign o_k     = r_k;

  // k steps fastest, carrying into n and then m; everything wraps back to zero after the last step
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (i_inc) begin
      if (w_k_max) begin
        r_k <= '0;
        if (w_n_max) begin
          r_n <= '0;
          r_m <= w_m_max ? '0 : r_m + MW'(1);
        end else begin
          r_n <= r_n + NW'(1);
        end
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/vx_tcu_uop_seq.sv
// Expands one WMMA instruction into M_STEPS*N_STEPS*K_STEPS TCU micro-ops with sop/eop framing.
// Latency: first uop valid the cycle after acceptance; back-to-back instructions issue with no bubble.
// Backpressure: a stalled uop holds its fields and payload; in_ready only opens when idle or on the last uop's handshake.
module vx_tcu_uop_seq
  import vx_tcu_uop_seq_pkg::*;
#(
  parameter int M_STEPS      = TCU_M_STEPS,
  parameter int N_STEPS      = TCU_N_STEPS,
  parameter int K_STEPS      = TCU_K_STEPS,
  parameter int A_SUB_BLOCKS = TCU_A_SUB_BLOCKS,
  parameter int B_SUB_BLOCKS = TCU_B_SUB_BLOCKS,
  parameter int RA           = TCU_RA,
  parameter int RB           = TCU_RB,
  parameter int RC           = TCU_RC,
  parameter int DATAW        = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [DATAW-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [DATAW-1:0] o_out_data,
  output tcu_uop_t         o_out_uop
);

  localparam int MW      = up_clog2(M_STEPS);
  localparam int NW      = up_clog2(N_STEPS);
  localparam int KW      = up_clog2(K_STEPS);
  localparam int A_SHIFT = $clog2(A_SUB_BLOCKS);
  localparam int B_SHIFT = $clog2(B_SUB_BLOCKS);

  tcu_seq_state_e   r_state;
  logic [DATAW-1:0] r_data;

  logic [MW-1:0]    w_m;
  logic [NW-1:0]    w_n;
  logic [KW-1:0]    w_k;
  logic             w_last;
  logic             w_accept;
  logic             w_fire;
  logic [31:0]      w_a_idx;
  logic [31:0]      w_b_idx;

  // The output stage is the state register: BUSY means a uop is being presented
  assign o_out_valid = (r_state == S_BUSY);
  assign o_in_ready  = (r_state == S_IDLE) || ((r_state == S_BUSY) && w_last && i_out_ready);
  assign o_out_data  = r_data;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_fire      = o_out_valid && i_out_ready;

  vx_tcu_uop_seq_step_ctr #(
    .M_STEPS (M_STEPS),
    .N_STEPS (N_STEPS),
    .K_STEPS (K_STEPS)
  ) u_step_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_accept),
    .i_inc   (w_fire && !w_last),
    .o_m     (w_m),
    .o_n     (w_n),
    .o_k     (w_k),
    .o_last  (w_last)
  );

  // Sequencer: latch payload on accept, return to IDLE after the last uop unless a new instruction is waiting
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_data  <= i_in_data;
          end
        end
        S_BUSY: begin
          if (w_fire && w_last) begin
            if (i_in_valid) begin
              r_data <= i_in_data;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Uop fields decoded from the step counters; sub-block counts are powers of two so div/mod are shift/mask
  always_comb begin
    w_a_idx = 32'(w_m) * 32'(K_STEPS) + 32'(w_k);
    w_b_idx = 32'(w_n) * 32'(K_STEPS) + 32'(w_k);
    o_out_uop        = '0;
    o_out_uop.step_m = TCU_STEP_M_BITS'(w_m);
    o_out_uop.step_n = TCU_STEP_N_BITS'(w_n);
    o_out_uop.step_k = TCU_STEP_K_BITS'(w_k);
    o_out_uop.rs1    = NUM_REGS_BITS'(32'(RA) + (w_a_idx >> A_SHIFT));
    o_out_uop.rs2    = NUM_REGS_BITS'(32'(RB) + (w_b_idx >> B_SHIFT));
    o_out_uop.rs3    = NUM_REGS_BITS'(32'(RC) + 32'(w_m) * 32'(N_STEPS) + 32'(w_n));
    o_out_uop.rd     = o_out_uop.rs3;
    o_out_uop.a_sub  = TCU_A_SUB_BITS'(w_a_idx & 32'(A_SUB_BLOCKS - 1));
    o_out_uop.b_sub  = TCU_B_SUB_BITS'(w_b_idx & 32'(B_SUB_BLOCKS - 1));
    o_out_uop.sop    = (w_m == '0) && (w_n == '0) && (w_k == '0);
    o_out_uop.eop    = w_last;
  end

endmodule
